// File: rtl/hilo_mult_unit_pkg.sv
// Shared definitions for the sequential HI/LO multiplier: FSM encoding and iteration counter width.
package hilo_mult_unit_pkg;

    localparam int MULT_DATA_WIDTH = 32;
    localparam int MULT_ITER_WIDTH = 6;

    typedef enum logic [1:0] {
        MULT_ST_IDLE = 2'd0,
        MULT_ST_RUN  = 2'd1,
        MULT_ST_FIX  = 2'd2
    } mult_state_t;

endpackage

// File: rtl/hilo_mult_unit_datapath.sv
// Radix-2 shift-add datapath: operand magnitudes, accumulator, shifting multiplicand/multiplier
// and the final two's-complement fix-up of the unsigned product.
module mult_seq_datapath
    import hilo_mult_unit_pkg::*;
#(
    parameter int WIDTH = MULT_DATA_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               negate;

    // |-2^(W-1)| wraps to 2^(W-1), which is still correct when read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            negate <= 1'b0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, (signed_op ? magnitude(a) : a)};
            mplier <= signed_op ? magnitude(b) : b;
            negate <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign product = negate ? (~acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;

endmodule

// File: rtl/hilo_mult_unit.sv
// Multi-cycle 32x32 MULT/MULTU unit with architectural HI/LO registers and MTHI/MTLO writes.
// The top owns the FSM, iteration counter and HI/LO; arithmetic lives in mult_seq_datapath.
module hilo_mult_unit
    import hilo_mult_unit_pkg::*;
#(
    parameter int WIDTH = MULT_DATA_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MTHI,
    input  logic             MTLO,
    input  logic [WIDTH-1:0] WDATA,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [MULT_ITER_WIDTH-1:0] LAST_ITER = MULT_ITER_WIDTH'(WIDTH - 1);

    mult_state_t                state;
    mult_state_t                state_next;
    logic [MULT_ITER_WIDTH-1:0] cnt;
    logic                       load;
    logic                       step;
    logic                       fix;
    logic                       mt_allowed;
    logic [2*WIDTH-1:0]         product;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= MULT_ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;
        mt_allowed = 1'b0;
        case (state)
            MULT_ST_IDLE: begin
                // START takes priority over direct writes in the same cycle.
                if (START) begin
                    load       = 1'b1;
                    state_next = MULT_ST_RUN;
                end else begin
                    mt_allowed = 1'b1;
                end
            end
            MULT_ST_RUN: begin
                step = 1'b1;
                if (cnt == LAST_ITER) begin
                    state_next = MULT_ST_FIX;
                end
            end
            MULT_ST_FIX: begin
                fix        = 1'b1;
                state_next = MULT_ST_IDLE;
            end
            default: state_next = MULT_ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            HI   <= '0;
            LO   <= '0;
            DONE <= 1'b0;
        end else begin
            DONE <= fix;
            if (fix) begin
                {HI, LO} <= product;
            end else if (mt_allowed) begin
                if (MTHI) HI <= WDATA;
                if (MTLO) LO <= WDATA;
            end
        end
    end

    assign BUSY = (state != MULT_ST_IDLE);

    mult_seq_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk       (CLK),
        .rst_n     (RST),
        .load      (load),
        .step      (step),
        .signed_op (SIGNED),
        .a         (A),
        .b         (B),
        .product   (product)
    );

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Scoreboard bench for hilo_mult_unit: stimulus pushes expected HI/LO and completion cycle,
// a negedge monitor pops and compares whenever DONE is presented.
module tb_hilo_mult_unit;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic         SIGNED = 1'b0;
    logic         MTHI = 1'b0;
    logic         MTLO = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] WDATA = '0;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] HI;
    logic [W-1:0] LO;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_seen = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           at;
    } exp_t;

    exp_t sb[$];

    hilo_mult_unit #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .SIGNED(SIGNED),
        .A     (A),
        .B     (B),
        .MTHI  (MTHI),
        .MTLO  (MTLO),
        .WDATA (WDATA),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every DONE must match the oldest outstanding multiply, in value and in timing.
    always @(negedge CLK) begin
        if (RST && DONE) begin
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product_hi", 64'(HI), 64'(e.hi));
                check("product_lo", 64'(LO), 64'(e.lo));
                check("done_latency", 64'(cyc), 64'(e.at));
                check("busy_low_with_done", 64'(BUSY), 64'd0);
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    // Called one step after a negedge; START is sampled at the next rising edge k = cyc+1,
    // so DONE is visible after edge k+33.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        e.at = cyc + 34;
        sb.push_back(e);
        A = a;
        B = b;
        SIGNED = s;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((BUSY || sb.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("wait_idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!DONE && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("wait_done_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        logic [W-1:0] hold;
        int d0;

        #2 RST = 1'b0;
        tick();
        check("reset_busy", 64'(BUSY), 64'd0);
        check("reset_done", 64'(DONE), 64'd0);
        check("reset_hi", 64'(HI), 64'd0);
        check("reset_lo", 64'(LO), 64'd0);
        RST = 1'b1;
        tick();

        // Unsigned products
        issue(32'd10, 32'd20, 1'b0, 32'h0000_0000, 32'h0000_00C8);
        wait_idle();
        issue(32'h7000_0000, 32'h7000_0000, 1'b0, 32'h3100_0000, 32'h0000_0000);
        wait_idle();

        // Signed products
        issue(-32'sd3, -32'sd15, 1'b1, 32'h0000_0000, 32'h0000_002D);
        wait_idle();
        issue(-32'sd16, 32'sd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF90);
        wait_idle();
        issue(32'h9000_0000, 32'h7000_0000, 1'b1, 32'hCF00_0000, 32'h0000_0000);
        wait_idle();

        // Extremes
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        wait_idle();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001);
        wait_idle();
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);
        wait_idle();

        // Direct writes in IDLE
        WDATA = 32'hDEAD_BEEF;
        MTHI = 1'b1;
        tick();
        MTHI = 1'b0;
        check("mthi_idle", 64'(HI), 64'hDEAD_BEEF);
        check("mthi_lo_untouched", 64'(LO), 64'h0);
        WDATA = 32'h0BAD_F00D;
        MTHI = 1'b1;
        MTLO = 1'b1;
        tick();
        MTHI = 1'b0;
        MTLO = 1'b0;
        check("mt_both_hi", 64'(HI), 64'h0BAD_F00D);
        check("mt_both_lo", 64'(LO), 64'h0BAD_F00D);

        // START together with MTHI: write dropped, product computed
        WDATA = 32'h1234_5678;
        MTHI = 1'b1;
        issue(32'd6, 32'd7, 1'b0, 32'h0000_0000, 32'h0000_002A);
        MTHI = 1'b0;
        check("start_mthi_dropped", 64'(HI), 64'h0BAD_F00D);
        check("busy_after_start", 64'(BUSY), 64'd1);
        repeat (5) tick();
        // MTLO while busy is ignored
        WDATA = 32'hCAFE_CAFE;
        MTLO = 1'b1;
        tick();
        MTLO = 1'b0;
        check("mtlo_busy_ignored", 64'(LO), 64'h0BAD_F00D);
        wait_idle();

        // Back-to-back: START in the DONE cycle, plus a START while BUSY that must be ignored
        issue(32'd100, 32'd3, 1'b0, 32'h0000_0000, 32'h0000_012C);
        wait_done();
        issue(-32'sd2, 32'sd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF6);
        check("b2b_busy_no_gap", 64'(BUSY), 64'd1);
        repeat (3) tick();
        A = 32'd9;
        B = 32'd9;
        SIGNED = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        wait_idle();

        // Reset mid-operation aborts without a DONE pulse
        hold = LO;
        check("pre_reset_lo_nonzero", 64'(hold != 0), 64'd1);
        A = 32'd10;
        B = 32'd20;
        SIGNED = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (14) tick();
        d0 = done_seen;
        RST = 1'b0;
        #1;
        check("abort_hi", 64'(HI), 64'd0);
        check("abort_lo", 64'(LO), 64'd0);
        check("abort_busy", 64'(BUSY), 64'd0);
        repeat (2) tick();
        RST = 1'b1;
        repeat (40) tick();
        check("abort_no_done", 64'(done_seen - d0), 64'd0);
        check("abort_idle", 64'(BUSY), 64'd0);

        // Normal operation after abort
        issue(32'd10, 32'd20, 1'b0, 32'h0000_0000, 32'h0000_00C8);
        wait_idle();

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
